pe_command_sequencer: RTL



---
 rtl/pe_array_pkg.sv | 19 +
 rtl/pe_command_sequencer_cmd_fifo.sv | 37 +++
 rtl/pe_command_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pe_array_pkg.sv
// pe_array_pkg: opcodes, sequencer states and instruction layout shared by the PE command path
package pe_array_pkg;
  localparam logic [3:0] MUL = 4'd0;
  localparam logic [3:0] SHU = 4'd1;
  localparam logic [3:0] SHD = 4'd2;
  localparam logic [3:0] SHL = 4'd3;
  localparam logic [3:0] SHR = 4'd4;
  localparam logic [3:0] WRA = 4'd5;
  localparam logic [3:0] WRB = 4'd6;
  localparam logic [3:0] WRS = 4'd7;
  localparam logic [3:0] RST = 4'd8;
  localparam logic [3:0] NOP = 4'hF;
  localparam int OP_W = 4;
  localparam int RPT_W = 8;
  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_CLEAR, S_HALT} state_t;
  function automatic int instr_w(input int out_prec);
    return OP_W + RPT_W + out_prec;
  endfunction
endpackage

// File: rtl/pe_command_sequencer_cmd_fifo.sv
// cmd_fifo: synchronous instruction FIFO with a registered not-full flag used as the host ready
module cmd_fifo #(
  parameter int W = 44,
  parameter int DEPTH = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         ready
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, wp_n, rp_n;
  logic do_push, do_pop;
  assign do_push = push && ready;
  assign do_pop = pop && !empty;
  assign wp_n = wp + (AW+1)'(do_push);
  assign rp_n = rp + (AW+1)'(do_pop);
  assign empty = wp == rp;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge CLK)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      ready <= 1'b0;
    end else begin
      wp <= wp_n;
      rp <= rp_n;
      ready <= (wp_n - rp_n) != (AW+1)'(DEPTH);
    end
  always_ff @(posedge CLK)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/pe_command_sequencer.sv
// pe_command_sequencer: pops host instructions and runs the issue/ready/ack/clear handshake with the PE array
module pe_command_sequencer
  import pe_array_pkg::*;
#(
  parameter int PRECISION = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int NUM_PE = 16,
  parameter int DEPTH = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [3:0]                  cmd_op,
  input  logic [7:0]                  cmd_rpt,
  input  logic [OUTPUT_PRECISION-1:0] cmd_data,
  output logic [3:0]                  command_to_execute,
  output logic [PRECISION-1:0]        a_overwrite,
  output logic [PRECISION-1:0]        b_overwrite,
  output logic [OUTPUT_PRECISION-1:0] s_out_overwrite,
  input  logic [NUM_PE-1:0]           pe_ready,
  output logic                        ack,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err,
  output logic                        illegal_op
);
  localparam int IW = instr_w(OUTPUT_PRECISION);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] head;
  logic empty, pop, timed_out, init_q;
  logic [3:0] head_op, op_q;
  logic [7:0] head_rpt, rpt_q;
  logic [OUTPUT_PRECISION-1:0] head_data;
  logic [CW-1:0] cnt;
  state_t state;
  assign head_op = head[IW-1 -: OP_W];
  assign head_rpt = head[IW-OP_W-1 -: RPT_W];
  assign head_data = head[OUTPUT_PRECISION-1:0];
  assign pop = state == S_IDLE && !empty;
  assign timed_out = cnt == CW'(TIMEOUT - 1);
  cmd_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (cmd_valid),
    .wdata ({cmd_op, cmd_rpt, cmd_data}),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .ready (cmd_ready)
  );
  // outputs are assigned on the transition into the state they belong to
  always_ff @(posedge CLK)
    if (reset) begin
      state <= S_SYNC;
      command_to_execute <= NOP;
      ack <= 1'b0;
      a_overwrite <= '0;
      b_overwrite <= '0;
      s_out_overwrite <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      illegal_op <= 1'b0;
      op_q <= NOP;
      rpt_q <= '0;
      cnt <= '0;
      init_q <= 1'b1;
    end else begin
      done <= 1'b0;
      busy <= state != S_IDLE || !empty;
      command_to_execute <= NOP;
      ack <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        S_SYNC: begin
          ack <= 1'b1;
          cnt <= '0;
          state <= S_CLEAR;
        end
        S_IDLE:
          if (!empty) begin
            if (head_op <= RST) begin
              op_q <= head_op;
              rpt_q <= head_rpt;
              command_to_execute <= head_op;
              a_overwrite <= head_data[PRECISION-1:0];
              b_overwrite <= head_data[PRECISION-1:0];
              s_out_overwrite <= head_data;
              state <= S_ISSUE;
            end else illegal_op <= 1'b1;
          end
        S_ISSUE: begin
          cnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          if (&pe_ready) begin
            ack <= 1'b1;
            state <= S_ACK;
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            ack <= 1'b1;
            state <= S_HALT;
          end
        S_ACK: begin
          cnt <= '0;
          state <= S_CLEAR;
        end
        S_CLEAR:
          if (~|pe_ready) begin
            if (init_q) begin
              init_q <= 1'b0;
              state <= S_IDLE;
            end else if (rpt_q != 8'd0) begin
              rpt_q <= rpt_q - 1'b1;
              command_to_execute <= op_q;
              state <= S_ISSUE;
            end else begin
              done <= 1'b1;
              state <= S_IDLE;
            end
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            ack <= 1'b1;
            state <= S_HALT;
          end
        default: ack <= 1'b1;
      endcase
    end
endmodule
